prbs_sym_gen: RTL
=================

// Module: prbs_sym_gen
// PURPOSE
//  Parametrised maximal-length Galois LFSR payload generator for modem test data.
//  Advances SYM_BITS LFSR steps per clk_en and emits them as one registered symbol.
//  Tracks sequence period, supports runtime reseeding, and feeds mapper and BER/accumulator logic.
// PARAMETERS
//  LFSR_LEN   22     LFSR state width; legal range 2..32.
//  SYM_BITS   2      Bits per symbol (LFSR steps per clk_en); legal range 1..8.
//  SEED       1      Reset seed. Zero is illegal; 0 is replaced by 1.
//  CNT_W      32     Width of the symbol and period counters.
// PORTS
//  clk          in   1         System clock.
//  reset        in   1         Synchronous, active-high reset.
//  clk_en       in   1         Symbol strobe; one symbol per asserted cycle.
//  seed_load    in   1         Load seed_in into the state and reference seed.
//  seed_in      in   LFSR_LEN  Runtime seed; 0 is replaced by 1.
//  sym_out      out  SYM_BITS  Current symbol; first-generated bit is in the MSB.
//  sym_valid    out  1         One-cycle pulse when sym_out updates.
//  state_out    out  LFSR_LEN  Current LFSR state.
//  cycle_pulse  out  1         One-cycle pulse when the state returns to the reference seed.
//  cycle_seen   out  1         Sticky flag, set on the first cycle_pulse.
//  period_out   out  CNT_W     Symbols in the last completed cycle.
//  sym_count    out  CNT_W     Symbols emitted since the last cycle boundary or load.
//  err_inj      in   1         [PRBS_ERR_INJECT_EN only] Corrupt the next symbol.
//  err_count    out  CNT_W     [PRBS_ERR_INJECT_EN only] Count of injected errors.
// BEHAVIOUR
//  - Single step: b = s[0]; s' = s >> 1; if b, s' ^= TAPMASK.
//    Emitted bit = b.
//  - TAPMASK comes from an internal maximal-length table indexed by LFSR_LEN (2..32).
//    Examples: LFSR_LEN=4 -> 4'hC; LFSR_LEN=22 -> 22'h300000.
//  - Per clk_en, SYM_BITS steps are unrolled combinationally; all outputs are registered.
//    sym_out/state_out update at the clk_en edge; sym_valid is high the following cycle only.
//  - Reset values:
//    - state = ref_seed = SEED (0 is replaced by 1).
//    - sym_out = 0, sym_valid = 0, cycle_pulse = 0, cycle_seen = 0.
//    - period_out = 0, sym_count = 0, err_count = 0.
//  - seed_load: state <= ref_seed <= seed_in (0 is replaced by 1).
//    sym_count <= 0; cycle_seen and period_out are unchanged; no symbol is emitted.
//  - seed_load and clk_en in the same cycle: the load wins and the strobe is dropped.
//  - Cycle boundary, when the post-advance state == ref_seed on a clk_en:
//    - cycle_pulse = 1 for one cycle; cycle_seen <= 1.
//    - period_out <= sym_count + 1; sym_count <= 0.
//    - Otherwise sym_count increments, wrapping at 2^CNT_W.
//  - Period in symbols = (2^LFSR_LEN - 1) / gcd(SYM_BITS, 2^LFSR_LEN - 1).
//  - The all-zero state is unreachable by construction. The RTL also forces state 0 -> 1 as a guard.
//  - clk_en low: all state is held; sym_valid and cycle_pulse are 0.
//  - reset asserted mid-stream: returns every output to its reset value on the next edge.
// CONFIGURATION
//  PRBS_ERR_INJECT_EN defined:
//    - The err_inj and err_count ports exist.
//    - err_inj sampled with clk_en: sym_out[0] is inverted for that symbol only; LFSR state is unaffected.
//    - err_count increments per injected error; it is cleared by reset only.
//    - err_inj without clk_en is ignored.
//  PRBS_ERR_INJECT_EN undefined:
//    - err_inj and err_count are absent.
//    - sym_out is always the pure sequence.
// TESTING
//  1. LFSR_LEN=4, SYM_BITS=1, SEED=1, clk_en held high
//     -> sym_out sequence 1,0,0,1,1,0,1,0,1,1,1,1,0,0,0.
//     -> cycle_pulse on the 15th symbol; period_out=15.
//  2. LFSR_LEN=4, SYM_BITS=2, SEED=1
//     -> first symbols 2'b10, 2'b01; state_out 4'h6 then 4'hD.
//     -> period_out=15 after 15 strobes.
//  3. LFSR_LEN=4, SYM_BITS=3
//     -> cycle_pulse every 5 strobes; period_out=5; cycle_seen stays 1.
//  4. After 7 strobes, seed_load with seed_in=0 and clk_en in the same cycle
//     -> state_out=1, sym_count=0, sym_valid=0 next cycle.
//     -> the next cycle_pulse comes 15 strobes later.
//  5. LFSR_LEN=22, SYM_BITS=2, run 4194305 strobes
//     -> the single cycle_pulse occurs at strobe 4194303; period_out=4194303.
//     -> reset asserted mid-run clears all outputs in one cycle.
//  6. PRBS_ERR_INJECT_EN, LFSR_LEN=4, SYM_BITS=1: err_inj on strobe 1
//     -> sym_out=0 instead of 1; err_count=1.
//     -> strobe 2 sym_out=0 (uncorrupted); state_out matches test 1.

Source files
------------

// File: rtl/prbs_sym_gen.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_sym_gen
//  Description : Maximal-length Galois LFSR payload generator for modem test
//                data. Each clk_en advances the LFSR SYM_BITS steps
//                (combinationally unrolled) and emits the produced bits as one
//                registered symbol, first-generated bit in the MSB. Tracks the
//                sequence period against a reference seed and supports
//                runtime reseeding.
//
//  Optional feature macro: PRBS_ERR_INJECT_EN
//    When defined, adds err_inj / err_count. An err_inj sampled together with
//    a taken clk_en inverts sym_out[0] of that symbol only; the LFSR state is
//    not disturbed. err_count is cleared by reset only.
//
//  Ports
//    clk          in   1         system clock
//    reset        in   1         synchronous, active-high reset
//    clk_en       in   1         symbol strobe, one symbol per asserted cycle
//    seed_load    in   1         load seed_in into state and reference seed
//    seed_in      in   LFSR_LEN  runtime seed (0 is replaced by 1)
//    sym_out      out  SYM_BITS  current symbol
//    sym_valid    out  1         one-cycle pulse when sym_out updates
//    state_out    out  LFSR_LEN  current LFSR state
//    cycle_pulse  out  1         state returned to the reference seed
//    cycle_seen   out  1         sticky, set on the first cycle_pulse
//    period_out   out  CNT_W     symbols in the last completed cycle
//    sym_count    out  CNT_W     symbols since last cycle boundary or load
//    err_inj      in   1         [PRBS_ERR_INJECT_EN] corrupt next symbol
//    err_count    out  CNT_W     [PRBS_ERR_INJECT_EN] injected error count
//
//  Revision    : 1.0  initial release
// ============================================================================
module prbs_sym_gen #(
  parameter int LFSR_LEN = 22,   // 2..32
  parameter int SYM_BITS = 2,    // 1..8
  parameter int SEED     = 1,    // 0 is replaced by 1
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                seed_load,
  input  logic [LFSR_LEN-1:0] seed_in,
`ifdef PRBS_ERR_INJECT_EN
  input  logic                err_inj,
  output logic [CNT_W-1:0]    err_count,
`endif
  output logic [SYM_BITS-1:0] sym_out,
  output logic                sym_valid,
  output logic [LFSR_LEN-1:0] state_out,
  output logic                cycle_pulse,
  output logic                cycle_seen,
  output logic [CNT_W-1:0]    period_out,
  output logic [CNT_W-1:0]    sym_count
);

  // --------------------------------------------------------------------------
  // Maximal-length feedback masks for the right-shifting Galois form.
  // Bit (t-1) is set for every tap t of the primitive polynomial.
  // --------------------------------------------------------------------------
  function automatic logic [31:0] tap_mask(input int len);
    logic [31:0] m;
    case (len)
      2:       m = 32'h0000_0003;
      3:       m = 32'h0000_0006;
      4:       m = 32'h0000_000C;
      5:       m = 32'h0000_0014;
      6:       m = 32'h0000_0030;
      7:       m = 32'h0000_0060;
      8:       m = 32'h0000_00B8;
      9:       m = 32'h0000_0110;
      10:      m = 32'h0000_0240;
      11:      m = 32'h0000_0500;
      12:      m = 32'h0000_0829;
      13:      m = 32'h0000_100D;
      14:      m = 32'h0000_2015;
      15:      m = 32'h0000_6000;
      16:      m = 32'h0000_D008;
      17:      m = 32'h0001_2000;
      18:      m = 32'h0002_0400;
      19:      m = 32'h0004_0023;
      20:      m = 32'h0009_0000;
      21:      m = 32'h0014_0000;
      22:      m = 32'h0030_0000;
      23:      m = 32'h0042_0000;
      24:      m = 32'h00E1_0000;
      25:      m = 32'h0120_0000;
      26:      m = 32'h0200_0023;
      27:      m = 32'h0400_0013;
      28:      m = 32'h0900_0000;
      29:      m = 32'h1400_0000;
      30:      m = 32'h2000_0029;
      31:      m = 32'h4800_0000;
      32:      m = 32'h8020_0003;
      default: m = 32'h0000_0003;
    endcase
    return m;
  endfunction

  localparam logic [LFSR_LEN-1:0] TAPMASK    = LFSR_LEN'(tap_mask(LFSR_LEN));
  localparam logic [LFSR_LEN-1:0] STATE_ONE  = LFSR_LEN'(1);
  localparam logic [LFSR_LEN-1:0] SEED_TRUNC = LFSR_LEN'(SEED);
  // A zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [LFSR_LEN-1:0] SEED_FIX   = (SEED_TRUNC == '0) ? STATE_ONE : SEED_TRUNC;
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [LFSR_LEN-1:0] state_q,     state_d;
  logic [LFSR_LEN-1:0] ref_seed_q,  ref_seed_d;
  logic [SYM_BITS-1:0] sym_q,       sym_d;
  logic                valid_q,     valid_d;
  logic                pulse_q,     pulse_d;
  logic                seen_q,      seen_d;
  logic [CNT_W-1:0]    period_q,    period_d;
  logic [CNT_W-1:0]    count_q,     count_d;
`ifdef PRBS_ERR_INJECT_EN
  logic [CNT_W-1:0]    err_cnt_q,   err_cnt_d;
`endif

  // --------------------------------------------------------------------------
  // Unrolled LFSR: step_state[g] is the state after g single steps; the bit
  // shifted out at step g lands at symbol position SYM_BITS-1-g so that the
  // earliest bit ends up in the MSB.
  // --------------------------------------------------------------------------
  logic [LFSR_LEN-1:0] step_state [0:SYM_BITS];
  logic [SYM_BITS-1:0] step_bits;

  assign step_state[0] = state_q;

  for (genvar g = 0; g < SYM_BITS; g++) begin : g_step
    assign step_bits[SYM_BITS-1-g] = step_state[g][0];
    assign step_state[g+1] = (step_state[g] >> 1) ^ (step_state[g][0] ? TAPMASK : '0);
  end

  // All-zero cannot occur from a legal state; guard it anyway so an upset
  // cannot lock the generator.
  logic [LFSR_LEN-1:0] adv_state;
  assign adv_state = (step_state[SYM_BITS] == '0) ? STATE_ONE : step_state[SYM_BITS];

  logic [LFSR_LEN-1:0] seed_fix;
  assign seed_fix = (seed_in == '0) ? STATE_ONE : seed_in;

  logic inj_bit;
`ifdef PRBS_ERR_INJECT_EN
  assign inj_bit = err_inj;
`else
  assign inj_bit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic. A load takes priority and swallows a coincident strobe
  // (and any coincident error request).
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ref_seed_d = ref_seed_q;
    sym_d      = sym_q;
    valid_d    = 1'b0;
    pulse_d    = 1'b0;
    seen_d     = seen_q;
    period_d   = period_q;
    count_d    = count_q;
`ifdef PRBS_ERR_INJECT_EN
    err_cnt_d  = err_cnt_q;
`endif

    if (seed_load) begin
      state_d    = seed_fix;
      ref_seed_d = seed_fix;
      count_d    = '0;
    end else if (clk_en) begin
      state_d = adv_state;
      sym_d   = step_bits ^ SYM_BITS'(inj_bit);
      valid_d = 1'b1;
`ifdef PRBS_ERR_INJECT_EN
      if (err_inj) begin
        err_cnt_d = err_cnt_q + CNT_ONE;
      end
`endif
      // Boundary: this symbol brought the state back to the reference seed.
      if (adv_state == ref_seed_q) begin
        pulse_d  = 1'b1;
        seen_d   = 1'b1;
        period_d = count_q + CNT_ONE;
        count_d  = '0;
      end else begin
        count_d  = count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEED_FIX;
      ref_seed_q <= SEED_FIX;
      sym_q      <= '0;
      valid_q    <= 1'b0;
      pulse_q    <= 1'b0;
      seen_q     <= 1'b0;
      period_q   <= '0;
      count_q    <= '0;
`ifdef PRBS_ERR_INJECT_EN
      err_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ref_seed_q <= ref_seed_d;
      sym_q      <= sym_d;
      valid_q    <= valid_d;
      pulse_q    <= pulse_d;
      seen_q     <= seen_d;
      period_q   <= period_d;
      count_q    <= count_d;
`ifdef PRBS_ERR_INJECT_EN
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all straight from flops)
  // --------------------------------------------------------------------------
  assign sym_out     = sym_q;
  assign sym_valid   = valid_q;
  assign state_out   = state_q;
  assign cycle_pulse = pulse_q;
  assign cycle_seen  = seen_q;
  assign period_out  = period_q;
  assign sym_count   = count_q;
`ifdef PRBS_ERR_INJECT_EN
  assign err_count   = err_cnt_q;
`endif

endmodule
`default_nettype wire
